ucsbece154_lsu: RTL and testbench

- Dual-lane load/store unit; initiator side of the dual-port data memory (`ucsbece154_dmem`).
- Takes up to two memory ops per transaction from the superscalar execute stage, in program order: lane 1 is older.
- Drives word-aligned addresses and write enables on both memory ports.
- Performs byte/halfword extraction with sign/zero extension. Sub-word stores are done as read-modify-write, with defined ordering when both lanes hit the same word.

---
 rtl/ucsbece154_lsu_pkg.sv | 47 ++++
 rtl/ucsbece154_lsu_bytelane.sv | 42 ++++
 rtl/ucsbece154_lsu.sv | 168 ++++++++++++++++
 tb/tb_ucsbece154_lsu.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154_lsu_pkg.sv
// Shared types and helpers for the dual-lane load/store unit.
// Holds size codes, the FSM state encoding, the captured-request bundle
// and the alignment helpers used by the top and the byte-lane datapath.
package ucsbece154_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_DONE
    } lsu_state_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
    } lsu_req_t;

    // Size code 11 is handled as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            SIZE_W:  return |off;
            default: return |off;
        endcase
    endfunction

    // Drops the low offset bits that a given access size may not use.
    function automatic logic [1:0] align_off(input logic [1:0] size,
                                             input logic [1:0] off);
        case (size)
            SIZE_B:  return off;
            SIZE_H:  return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ucsbece154_lsu_bytelane.sv
// Combinational byte-lane datapath: load extract/extend and store merge.
// Ports: size/uns/off select the field, word is the source memory word,
// wdata the right-justified store data; rdata is the extended load value,
// merged is word with the selected bytes replaced by wdata.
module ucsbece154_lsu_bytelane
    import ucsbece154_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [15:0] field;
    logic [31:0] mask;

    assign sh    = {off, 3'b000};
    assign field = 16'(word >> sh);

    always_comb begin
        rdata = word;
        mask  = 32'hFFFF_FFFF;
        case (size)
            SIZE_B: begin
                rdata = {{24{~uns & field[7]}}, field[7:0]};
                mask  = 32'h0000_00FF << sh;
            end
            SIZE_H: begin
                rdata = {{16{~uns & field[15]}}, field};
                mask  = 32'h0000_FFFF << sh;
            end
            default: ;
        endcase
    end

    assign merged = (word & ~mask) | ((wdata << sh) & mask);

endmodule

// File: rtl/ucsbece154_lsu.sv
// Dual-lane load/store unit driving both ports of the data memory.
// Ports: req_* two-lane request (lane 1 older) with req_ready_o accept;
// resp_* one-cycle completion per lane with load data and misalign flag;
// mem_* word-aligned address, write enable and data per memory port,
// mem_rd_i* combinational read data. Sub-word stores are read-modify-write.
module ucsbece154_lsu
    import ucsbece154_lsu_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i1,
    input  logic        req_valid_i2,
    output logic        req_ready_o,
    input  logic        req_we_i1,
    input  logic        req_we_i2,
    input  logic [31:0] req_addr_i1,
    input  logic [31:0] req_addr_i2,
    input  logic [31:0] req_wdata_i1,
    input  logic [31:0] req_wdata_i2,
    input  logic [1:0]  req_size_i1,
    input  logic [1:0]  req_size_i2,
    input  logic        req_unsigned_i1,
    input  logic        req_unsigned_i2,
    output logic        resp_valid_o1,
    output logic        resp_valid_o2,
    output logic [31:0] resp_rdata_o1,
    output logic [31:0] resp_rdata_o2,
    output logic        misalign_o1,
    output logic        misalign_o2,
    output logic [31:0] mem_a_o1,
    output logic [31:0] mem_a_o2,
    output logic        mem_we_o1,
    output logic        mem_we_o2,
    output logic [31:0] mem_wd_o1,
    output logic [31:0] mem_wd_o2,
    input  logic [31:0] mem_rd_i1,
    input  logic [31:0] mem_rd_i2
);

    lsu_state_t  state, state_n;
    lsu_req_t    r1, r2;
    logic [31:0] old1, old2;
    logic [1:0]  off1, off2;
    logic        mis1, mis2, st1, st2;
    logic        same, fwd, both_st;
    logic [31:0] word2, ld1, ld2, mg1, mg2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1   <= '0;
            r2   <= '0;
            old1 <= '0;
            old2 <= '0;
        end else begin
            if (state == ST_IDLE && (req_valid_i1 || req_valid_i2)) begin
                r1 <= '{req_valid_i1, req_we_i1, req_addr_i1,
                        req_wdata_i1, req_size_i1, req_unsigned_i1};
                r2 <= '{req_valid_i2, req_we_i2, req_addr_i2,
                        req_wdata_i2, req_size_i2, req_unsigned_i2};
            end
            if (state == ST_ACCESS) begin
                old1 <= mem_rd_i1;
                old2 <= mem_rd_i2;
            end
        end
    end

    // With checking off the offset is coerced; with it on, a misaligned
    // lane is suppressed, so coercing is harmless either way.
    assign off1 = align_off(r1.size, r1.addr[1:0]);
    assign off2 = align_off(r2.size, r2.addr[1:0]);
    assign mis1 = MISALIGN_CHECK && r1.valid
                  && is_misaligned(r1.size, r1.addr[1:0]);
    assign mis2 = MISALIGN_CHECK && r2.valid
                  && is_misaligned(r2.size, r2.addr[1:0]);
    assign st1  = r1.valid && r1.we && !mis1;
    assign st2  = r2.valid && r2.we && !mis2;

    // Lane 2 sees lane 1's store when both touch the same word.
    assign same    = r1.valid && r2.valid && !mis1 && !mis2
                     && (r1.addr[31:2] == r2.addr[31:2]);
    assign fwd     = same && st1;
    assign both_st = fwd && st2;
    assign word2   = fwd ? mg1 : old2;

    ucsbece154_lsu_bytelane u_lane1 (
        .size  (r1.size),
        .uns   (r1.uns),
        .off   (off1),
        .word  (old1),
        .wdata (r1.wdata),
        .rdata (ld1),
        .merged(mg1)
    );

    ucsbece154_lsu_bytelane u_lane2 (
        .size  (r2.size),
        .uns   (r2.uns),
        .off   (off2),
        .word  (word2),
        .wdata (r2.wdata),
        .rdata (ld2),
        .merged(mg2)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (req_valid_i1 || req_valid_i2) state_n = ST_ACCESS;
            ST_ACCESS: state_n = (st1 || st2) ? ST_WRITE : ST_DONE;
            ST_WRITE:  state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = 1'b0;
        resp_valid_o1 = 1'b0;
        resp_valid_o2 = 1'b0;
        resp_rdata_o1 = '0;
        resp_rdata_o2 = '0;
        misalign_o1   = 1'b0;
        misalign_o2   = 1'b0;
        mem_a_o1      = '0;
        mem_a_o2      = '0;
        mem_we_o1     = 1'b0;
        mem_we_o2     = 1'b0;
        mem_wd_o1     = '0;
        mem_wd_o2     = '0;
        if (state == ST_ACCESS || state == ST_WRITE) begin
            if (r1.valid) mem_a_o1 = {r1.addr[31:2], 2'b00};
            if (r2.valid) mem_a_o2 = {r2.addr[31:2], 2'b00};
        end
        case (state)
            ST_IDLE: req_ready_o = 1'b1;
            ST_WRITE: begin
                // Same-word store pair collapses onto port 1.
                if (both_st) begin
                    mem_we_o1 = 1'b1;
                    mem_wd_o1 = mg2;
                end else begin
                    mem_we_o1 = st1;
                    mem_wd_o1 = st1 ? mg1 : '0;
                    mem_we_o2 = st2;
                    mem_wd_o2 = st2 ? mg2 : '0;
                end
            end
            ST_DONE: begin
                resp_valid_o1 = r1.valid;
                resp_valid_o2 = r2.valid;
                misalign_o1   = mis1;
                misalign_o2   = mis2;
                if (r1.valid && !r1.we && !mis1) resp_rdata_o1 = ld1;
                if (r2.valid && !r2.we && !mis2) resp_rdata_o2 = ld2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ucsbece154_lsu.sv
// Self-checking bench for ucsbece154_lsu: directed vector table,
// randomized transactions against a program-order memory model.
module tb_ucsbece154_lsu;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        uns;
    } lane_t;

    typedef struct {
        lane_t       a;
        lane_t       b;
        int          p0i;
        logic [31:0] p0v;
        int          p1i;
        logic [31:0] p1v;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_m1;
        logic        e_m2;
        int          e_lat;
        int          e_we2;
        int          ci;
        logic [31:0] cv;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i1 = 0, req_valid_i2 = 0;
    logic        v01 = 0, v02 = 0;
    logic        req_we_i1 = 0, req_we_i2 = 0;
    logic [31:0] req_addr_i1 = 0, req_addr_i2 = 0;
    logic [31:0] req_wdata_i1 = 0, req_wdata_i2 = 0;
    logic [1:0]  req_size_i1 = 0, req_size_i2 = 0;
    logic        req_unsigned_i1 = 0, req_unsigned_i2 = 0;

    logic        req_ready_o, resp_valid_o1, resp_valid_o2;
    logic [31:0] resp_rdata_o1, resp_rdata_o2;
    logic        misalign_o1, misalign_o2;
    logic [31:0] mem_a_o1, mem_a_o2, mem_wd_o1, mem_wd_o2;
    logic        mem_we_o1, mem_we_o2;
    logic [31:0] mem_rd_i1, mem_rd_i2;

    logic        d0_rdy, d0_rv1, d0_rv2, d0_m1, d0_m2;
    logic [31:0] d0_rd1, d0_rd2, d0_a1, d0_a2, d0_wd1, d0_wd2;
    logic        d0_we1, d0_we2;
    logic [31:0] d0_mr1, d0_mr2;

    logic [31:0] mem  [64];
    logic [31:0] mem0 [64];
    logic [31:0] refmem [64];
    logic        pre_en = 0, pre_clr = 0;
    logic [5:0]  pre_idx = 0;
    logic [31:0] pre_val = 0;

    int n_tot = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ucsbece154_lsu dut (
        .clk(clk), .reset(reset),
        .req_valid_i1(req_valid_i1), .req_valid_i2(req_valid_i2),
        .req_ready_o(req_ready_o),
        .req_we_i1(req_we_i1), .req_we_i2(req_we_i2),
        .req_addr_i1(req_addr_i1), .req_addr_i2(req_addr_i2),
        .req_wdata_i1(req_wdata_i1), .req_wdata_i2(req_wdata_i2),
        .req_size_i1(req_size_i1), .req_size_i2(req_size_i2),
        .req_unsigned_i1(req_unsigned_i1), .req_unsigned_i2(req_unsigned_i2),
        .resp_valid_o1(resp_valid_o1), .resp_valid_o2(resp_valid_o2),
        .resp_rdata_o1(resp_rdata_o1), .resp_rdata_o2(resp_rdata_o2),
        .misalign_o1(misalign_o1), .misalign_o2(misalign_o2),
        .mem_a_o1(mem_a_o1), .mem_a_o2(mem_a_o2),
        .mem_we_o1(mem_we_o1), .mem_we_o2(mem_we_o2),
        .mem_wd_o1(mem_wd_o1), .mem_wd_o2(mem_wd_o2),
        .mem_rd_i1(mem_rd_i1), .mem_rd_i2(mem_rd_i2)
    );

    ucsbece154_lsu #(.MISALIGN_CHECK(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid_i1(v01), .req_valid_i2(v02),
        .req_ready_o(d0_rdy),
        .req_we_i1(req_we_i1), .req_we_i2(req_we_i2),
        .req_addr_i1(req_addr_i1), .req_addr_i2(req_addr_i2),
        .req_wdata_i1(req_wdata_i1), .req_wdata_i2(req_wdata_i2),
        .req_size_i1(req_size_i1), .req_size_i2(req_size_i2),
        .req_unsigned_i1(req_unsigned_i1), .req_unsigned_i2(req_unsigned_i2),
        .resp_valid_o1(d0_rv1), .resp_valid_o2(d0_rv2),
        .resp_rdata_o1(d0_rd1), .resp_rdata_o2(d0_rd2),
        .misalign_o1(d0_m1), .misalign_o2(d0_m2),
        .mem_a_o1(d0_a1), .mem_a_o2(d0_a2),
        .mem_we_o1(d0_we1), .mem_we_o2(d0_we2),
        .mem_wd_o1(d0_wd1), .mem_wd_o2(d0_wd2),
        .mem_rd_i1(d0_mr1), .mem_rd_i2(d0_mr2)
    );

    // Dual-port data memory stand-ins: combinational read, write on edge.
    assign mem_rd_i1 = mem[mem_a_o1[7:2]];
    assign mem_rd_i2 = mem[mem_a_o2[7:2]];
    assign d0_mr1    = mem0[d0_a1[7:2]];
    assign d0_mr2    = mem0[d0_a2[7:2]];

    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]  <= '0;
                mem0[i] <= '0;
            end
        end
        if (pre_en) begin
            mem[pre_idx]  <= pre_val;
            mem0[pre_idx] <= pre_val;
        end
        if (mem_we_o1) mem[mem_a_o1[7:2]] <= mem_wd_o1;
        if (mem_we_o2) mem[mem_a_o2[7:2]] <= mem_wd_o2;
        if (d0_we1) mem0[d0_a1[7:2]] <= d0_wd1;
        if (d0_we2) mem0[d0_a2[7:2]] <= d0_wd2;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic lane_t mk(input logic v, input logic we,
                                 input logic [31:0] addr,
                                 input logic [31:0] wd,
                                 input logic [1:0] size, input logic uns);
        lane_t q;
        q.v = v; q.we = we; q.addr = addr;
        q.wd = wd; q.size = size; q.uns = uns;
        return q;
    endfunction

    // Reference: lanes executed one after the other in program order on a
    // word array, with misaligned ops rejected.
    function automatic void ref_lane(input lane_t q, output logic [31:0] rd,
                                     output logic mis, output logic st);
        int nb, w, off;
        logic [31:0] v;
        rd = '0; mis = 1'b0; st = 1'b0;
        if (!q.v) return;
        nb = (q.size == 2'd0) ? 1 : (q.size == 2'd1) ? 2 : 4;
        if ((q.addr % nb) != 0) begin
            mis = 1'b1;
            return;
        end
        w   = int'(q.addr[7:2]);
        off = int'(q.addr[1:0]);
        if (q.we) begin
            st = 1'b1;
            for (int i = 0; i < nb; i++)
                refmem[w][8*(off+i) +: 8] = q.wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++)
                v[8*i +: 8] = refmem[w][8*(off+i) +: 8];
            if (!q.uns && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx[5:0]; pre_val = val;
        refmem[idx] = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic drive(input lane_t a, input lane_t b);
        req_we_i1 = a.we; req_addr_i1 = a.addr; req_wdata_i1 = a.wd;
        req_size_i1 = a.size; req_unsigned_i1 = a.uns;
        req_we_i2 = b.we; req_addr_i2 = b.addr; req_wdata_i2 = b.wd;
        req_size_i2 = b.size; req_unsigned_i2 = b.uns;
    endtask

    task automatic run_txn(input lane_t a, input lane_t b,
                           output logic [31:0] rd1, output logic [31:0] rd2,
                           output logic m1, output logic m2,
                           output logic rv1, output logic rv2,
                           output int lat, output int w1n, output int w2n,
                           output logic dual);
        rd1 = '0; rd2 = '0; m1 = 0; m2 = 0; rv1 = 0; rv2 = 0;
        lat = -1; w1n = 0; w2n = 0; dual = 0;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready_o), 32'd1);
        drive(a, b);
        req_valid_i1 = a.v; req_valid_i2 = b.v;
        @(posedge clk);
        #1 req_valid_i1 = 0; req_valid_i2 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_we_o1) w1n++;
            if (mem_we_o2) w2n++;
            if (mem_we_o1 && mem_we_o2 && mem_a_o1 == mem_a_o2) dual = 1;
            if (resp_valid_o1 || resp_valid_o2) begin
                rd1 = resp_rdata_o1; rd2 = resp_rdata_o2;
                m1 = misalign_o1; m2 = misalign_o2;
                rv1 = resp_valid_o1; rv2 = resp_valid_o2;
                lat = k;
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("resp_pulse", {30'd0, resp_valid_o1, resp_valid_o2}, 32'd0);
    endtask

    function automatic int mem_diffs();
        int bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== refmem[i]) bad++;
        return bad;
    endfunction

    function automatic lane_t rnd_lane();
        lane_t q;
        q.v    = ($urandom_range(0, 3) != 0);
        q.we   = 1'($urandom_range(0, 1));
        q.addr = {28'h1000000, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3))};
        q.wd   = $urandom;
        q.size = 2'($urandom_range(0, 3));
        q.uns  = 1'($urandom_range(0, 1));
        return q;
    endfunction

    vec_t vt [8];

    initial begin
        logic [31:0] rd1, rd2, e1, e2;
        logic m1, m2, rv1, rv2, em1, em2, s1, s2, dual;
        int lat, w1n, w2n, bad;
        lane_t a, b, z;

        z = mk(0, 0, 0, 0, 0, 0);
        vt[0] = '{mk(1, 0, 32'h1000_0008, 0, 2, 0), z,
                  2, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF,
                  32'hDEAD_BEEF, 32'h0, 0, 0, 1, 0, 2, 32'hDEAD_BEEF};
        vt[1] = '{mk(1, 0, 32'h1000_0003, 0, 0, 0),
                  mk(1, 0, 32'h1000_0003, 0, 0, 1),
                  0, 32'h80FF_0011, 0, 32'h80FF_0011,
                  32'hFFFF_FF80, 32'h0000_0080, 0, 0, 1, 0,
                  0, 32'h80FF_0011};
        vt[2] = '{mk(1, 1, 32'h1000_0001, 32'hAA, 0, 0),
                  mk(1, 1, 32'h1000_0002, 32'hBBCC, 1, 0),
                  0, 32'h1122_3344, 0, 32'h1122_3344,
                  32'h0, 32'h0, 0, 0, 2, 0, 0, 32'hBBCC_AA44};
        vt[3] = '{mk(1, 1, 32'h1000_0010, 32'h1234_5678, 2, 0),
                  mk(1, 0, 32'h1000_0012, 0, 1, 0),
                  4, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF,
                  32'h0, 32'h0000_1234, 0, 0, 2, 0, 4, 32'h1234_5678};
        vt[4] = '{mk(1, 0, 32'h1000_0006, 0, 2, 0),
                  mk(1, 0, 32'h1000_0000, 0, 2, 0),
                  1, 32'h5566_7788, 0, 32'hA5A5_A5A5,
                  32'h0, 32'hA5A5_A5A5, 1, 0, 1, 0, 1, 32'h5566_7788};
        vt[5] = '{mk(1, 0, 32'h1000_0020, 0, 2, 0),
                  mk(1, 1, 32'h1000_0022, 32'h77, 0, 0),
                  8, 32'h0102_0304, 8, 32'h0102_0304,
                  32'h0102_0304, 32'h0, 0, 0, 2, 1, 8, 32'h0177_0304};
        vt[6] = '{mk(1, 1, 32'h1000_0031, 32'hDDEE, 1, 0), z,
                  12, 32'hCAFE_BABE, 12, 32'hCAFE_BABE,
                  32'h0, 32'h0, 1, 0, 1, 0, 12, 32'hCAFE_BABE};
        vt[7] = '{z, mk(1, 0, 32'h1000_0038, 0, 3, 0),
                  14, 32'h89AB_CDEF, 14, 32'h89AB_CDEF,
                  32'h0, 32'h89AB_CDEF, 0, 0, 1, 0, 14, 32'h89AB_CDEF};

        for (int i = 0; i < 64; i++) refmem[i] = '0;
        pre_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 pre_clr = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_resp", {30'd0, resp_valid_o1, resp_valid_o2}, 32'd0);
        chk("rst_we", {30'd0, mem_we_o1, mem_we_o2}, 32'd0);
        chk("rst_addr", mem_a_o1 | mem_a_o2, 32'd0);
        chk("rst_rdata", resp_rdata_o1 | resp_rdata_o2, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            preload(vt[i].p0i, vt[i].p0v);
            preload(vt[i].p1i, vt[i].p1v);
            ref_lane(vt[i].a, e1, em1, s1);
            ref_lane(vt[i].b, e2, em2, s2);
            run_txn(vt[i].a, vt[i].b, rd1, rd2, m1, m2, rv1, rv2,
                    lat, w1n, w2n, dual);
            chk($sformatf("vec%0d_rd1", i), rd1, vt[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i), rd2, vt[i].e_rd2);
            chk($sformatf("vec%0d_mis", i), {30'd0, m1, m2},
                {30'd0, vt[i].e_m1, vt[i].e_m2});
            chk($sformatf("vec%0d_rv", i), {30'd0, rv1, rv2},
                {30'd0, vt[i].a.v, vt[i].b.v});
            chk($sformatf("vec%0d_lat", i), lat, vt[i].e_lat);
            chk($sformatf("vec%0d_we2", i), w2n, vt[i].e_we2);
            chk($sformatf("vec%0d_mem", i), mem[vt[i].ci], vt[i].cv);
        end

        for (int i = 0; i < 4; i++) preload(i, $urandom);
        for (int t = 0; t < 150; t++) begin
            a = rnd_lane();
            b = rnd_lane();
            if (!a.v && !b.v) a.v = 1'b1;
            ref_lane(a, e1, em1, s1);
            ref_lane(b, e2, em2, s2);
            run_txn(a, b, rd1, rd2, m1, m2, rv1, rv2, lat, w1n, w2n, dual);
            chk("rnd_rd1", rd1, e1);
            chk("rnd_rd2", rd2, e2);
            chk("rnd_mis", {30'd0, m1, m2}, {30'd0, em1, em2});
            chk("rnd_rv", {30'd0, rv1, rv2}, {30'd0, a.v, b.v});
            chk("rnd_lat", lat, (s1 || s2) ? 2 : 1);
            chk("rnd_dual_write", 32'(dual), 32'd0);
            bad = mem_diffs();
            chk("rnd_mem_words_bad", bad, 0);
        end

        // Coercing variant: misaligned word load reads the aligned word.
        preload(1, 32'h5566_7788);
        preload(0, 32'hA5A5_A5A5);
        @(negedge clk);
        drive(mk(1, 0, 32'h1000_0006, 0, 2, 0),
              mk(1, 0, 32'h1000_0000, 0, 2, 0));
        v01 = 1; v02 = 1;
        @(posedge clk);
        #1 v01 = 0; v02 = 0;
        @(negedge clk);
        chk("nc_addr1", d0_a1, 32'h1000_0004);
        @(posedge clk);
        @(negedge clk);
        chk("nc_rv", {30'd0, d0_rv1, d0_rv2}, 32'd3);
        chk("nc_rd1", d0_rd1, 32'h5566_7788);
        chk("nc_mis1", 32'(d0_m1), 32'd0);
        chk("nc_rd2", d0_rd2, 32'hA5A5_A5A5);

        // Reset while the store is being written.
        preload(20, 32'h0BAD_BEEF);
        @(negedge clk);
        drive(mk(1, 1, 32'h1000_0050, 32'hCAFE_F00D, 2, 0), z);
        req_valid_i1 = 1;
        @(posedge clk);
        #1 req_valid_i1 = 0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstw_we_before", 32'(mem_we_o1), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw_we_drop", 32'(mem_we_o1), 32'd0);
        chk("rstw_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rv1 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid_o1 || resp_valid_o2) rv1 = 1;
        end
        chk("rstw_no_resp", 32'(rv1), 32'd0);
        chk("rstw_mem", mem[20], 32'h0BAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
